// File: rtl/camera_readout.sv
// camera_readout: four-pixel single-slope ADC capture with two-pixel burst readout.
// Define GRAY_OUT_EN to present Data as the Gray code of the stored value.
module camera_readout (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Erase,
  input  logic       Expose,
  input  logic       ADC,
  input  logic       NRE_1,
  input  logic       NRE_2,
  input  logic [3:0] Cmp,
  output logic [7:0] Ramp,
  output logic [7:0] Data,
  output logic       Data_valid,
  output logic [1:0] Pix_addr,
  output logic       Busy,
  output logic       Err
);
  typedef enum logic [2:0] {IDLE, ERASE, CONVERT, READ_A, READ_B} state_t;
  state_t state_q, state_d;
  logic [7:0] ramp_q, ramp_d, data_q, data_d;
  logic [1:0] addr_q, addr_d;
  logic [3:0] done_q, done_d;
  logic [3:0][7:0] mem_q, mem_d;
  logic valid_q, valid_d, err_q, err_d, row_q, row_d;
  logic adc_q, nre1_q, nre2_q;
  logic adc_rise, nre1_rise, nre2_rise;

  function automatic logic [7:0] enc(input logic [7:0] v);
`ifdef GRAY_OUT_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  assign adc_rise   = ADC & ~adc_q;
  assign nre1_rise  = NRE_1 & ~nre1_q;
  assign nre2_rise  = NRE_2 & ~nre2_q;
  assign Ramp       = ramp_q;
  assign Data       = data_q;
  assign Data_valid = valid_q;
  assign Pix_addr   = addr_q;
  assign Err        = err_q;
  assign Busy       = state_q == CONVERT || state_q == READ_A || state_q == READ_B;

  always_comb begin
    state_d = state_q;
    ramp_d  = ramp_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    row_d   = row_q;
    mem_d   = mem_q;
    done_d  = done_q;
    err_d   = err_q | (ADC & Expose) | (ADC & (NRE_1 | NRE_2)) | (nre1_rise & nre2_rise);
    if (Erase) begin
      state_d = ERASE;
      ramp_d  = 8'd0;
      mem_d   = '0;
      done_d  = 4'd0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (adc_rise) begin
            state_d = CONVERT;
            ramp_d  = 8'd0;
          end else if (nre1_rise != nre2_rise) begin
            state_d = READ_A;
            row_d   = nre2_rise;
            addr_d  = {nre2_rise, 1'b0};
            data_d  = enc(mem_q[{nre2_rise, 1'b0}]);
            valid_d = 1'b1;
          end
        end
        CONVERT: begin
          // The ADC-low cycle still honours comparators, then fills untripped pixels with full scale.
          for (int k = 0; k < 4; k++) begin
            if (Cmp[k] && !done_q[k]) begin
              mem_d[k]  = ramp_q;
              done_d[k] = 1'b1;
            end else if (!ADC && !done_q[k]) begin
              mem_d[k] = 8'hFF;
            end
          end
          if (ADC) begin
            ramp_d = ramp_q + {7'd0, ramp_q != 8'hFF};
          end else begin
            done_d  = 4'hF;
            state_d = IDLE;
          end
        end
        READ_A: begin
          state_d = READ_B;
          addr_d  = {row_q, 1'b1};
          data_d  = enc(mem_q[{row_q, 1'b1}]);
          valid_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      ramp_q  <= 8'd0;
      data_q  <= 8'd0;
      addr_q  <= 2'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      row_q   <= 1'b0;
      mem_q   <= '0;
      done_q  <= 4'd0;
      adc_q   <= 1'b0;
      nre1_q  <= 1'b0;
      nre2_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ramp_q  <= ramp_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      row_q   <= row_d;
      mem_q   <= mem_d;
      done_q  <= done_d;
      adc_q   <= ADC;
      nre1_q  <= NRE_1;
      nre2_q  <= NRE_2;
    end
  end
endmodule

// File: tb/tb_camera_readout.sv
// tb_camera_readout: table-driven conversions with a readout scoreboard, plus error and reset corner cases.
module tb_camera_readout;
  logic clk = 0;
  logic Reset = 0, Erase = 0, Expose = 0, ADC = 0, NRE_1 = 0, NRE_2 = 0;
  logic [3:0] Cmp = 0;
  logic [7:0] Ramp, Data;
  logic [1:0] Pix_addr;
  logic Data_valid, Busy, Err;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic [1:0] a;
    logic [7:0] d;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    logic [8:0]      n;
    logic [3:0][8:0] thr;
    logic [7:0]      ramp;
    logic [3:0][7:0] mem;
  } vec_t;
  vec_t vecs[4];
  logic [3:0][8:0] thr;

  camera_readout dut (
    .clk(clk), .Reset(Reset), .Erase(Erase), .Expose(Expose), .ADC(ADC),
    .NRE_1(NRE_1), .NRE_2(NRE_2), .Cmp(Cmp), .Ramp(Ramp), .Data(Data),
    .Data_valid(Data_valid), .Pix_addr(Pix_addr), .Busy(Busy), .Err(Err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] enc(input logic [7:0] v);
`ifdef GRAY_OUT_EN
    return v ^ (v >> 1);
`else
    return v;
`endif
  endfunction

  function automatic vec_t mk(input int n, input int t0, t1, t2, t3, input int r, input int m0, m1, m2, m3);
    vec_t v;
    v.n = 9'(n);
    v.thr[0] = 9'(t0); v.thr[1] = 9'(t1); v.thr[2] = 9'(t2); v.thr[3] = 9'(t3);
    v.ramp = 8'(r);
    v.mem[0] = 8'(m0); v.mem[1] = 8'(m1); v.mem[2] = 8'(m2); v.mem[3] = 8'(m3);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (Reset && Data_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got Data_valid=1 addr=%0d expected Data_valid=0 at %0t", Pix_addr, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("burst_addr", 32'(Pix_addr), 32'(e.a));
        chk("burst_data", 32'(Data), 32'(e.d));
      end
    end
  end

  task automatic cmp_upd();
    for (int k = 0; k < 4; k++) Cmp[k] = {1'b0, Ramp} >= thr[k];
  endtask

  task automatic erase();
    @(negedge clk); Erase = 1;
    @(negedge clk); Erase = 0;
    @(negedge clk);
  endtask

  task automatic convert(input int n);
    logic ok;
    ok = 1'b1;
    @(negedge clk); ADC = 1; cmp_upd();
    repeat (n) begin
      @(negedge clk);
      ok &= Busy;
      cmp_upd();
    end
    ADC = 0;
    @(negedge clk);
    Cmp = 0;
    chk("busy_in_convert", 32'(ok), 1);
    chk("busy_after_convert", 32'(Busy), 0);
  endtask

  task automatic read_row(input int r, input logic [7:0] m0, input logic [7:0] m1);
    sb.push_back({2'(2 * r), enc(m0)});
    sb.push_back({2'(2 * r + 1), enc(m1)});
    @(negedge clk);
    if (r == 0) NRE_1 = 1; else NRE_2 = 1;
    repeat (4) @(negedge clk);
    NRE_1 = 0; NRE_2 = 0;
    @(negedge clk);
    chk("burst_complete", 32'(sb.size()), 0);
    chk("data_hold", 32'(Data), 32'(enc(m1)));
    sb.delete();
  endtask

  initial begin
    vecs[0] = mk(20, 256, 256, 256, 256, 19, 255, 255, 255, 255);
    vecs[1] = mk(20, 5, 9, 0, 256, 19, 5, 9, 0, 255);
    vecs[2] = mk(300, 200, 255, 100, 256, 255, 200, 255, 100, 255);
    vecs[3] = mk(5, 3, 3, 7, 2, 4, 3, 3, 255, 2);

    repeat (2) @(negedge clk);
    chk("rst_ramp", 32'(Ramp), 0);
    chk("rst_data", 32'(Data), 0);
    chk("rst_valid", 32'(Data_valid), 0);
    chk("rst_addr", 32'(Pix_addr), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_err", 32'(Err), 0);
    Reset = 1;

    for (int i = 0; i < 4; i++) begin
      erase();
      chk("erase_ramp", 32'(Ramp), 0);
      thr = vecs[i].thr;
      convert(int'(vecs[i].n));
      chk("final_ramp", 32'(Ramp), 32'(vecs[i].ramp));
      read_row(0, vecs[i].mem[0], vecs[i].mem[1]);
      read_row(1, vecs[i].mem[2], vecs[i].mem[3]);
      chk("no_err", 32'(Err), 0);
    end

    erase();
    @(negedge clk); NRE_1 = 1; NRE_2 = 1;
    repeat (3) @(negedge clk);
    chk("dual_nre_err", 32'(Err), 1);
    chk("dual_nre_no_valid", 32'(Data_valid), 0);
    NRE_1 = 0; NRE_2 = 0;
    erase();
    chk("erase_clears_err", 32'(Err), 0);

    @(negedge clk); Expose = 1; ADC = 1;
    @(negedge clk); Expose = 0; ADC = 0;
    @(negedge clk);
    chk("adc_expose_err", 32'(Err), 1);
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(Err), 1);
    erase();
    chk("erase_clears_err2", 32'(Err), 0);

    thr = {9'd256, 9'd256, 9'd256, 9'd5};
    convert(20);
    @(negedge clk); NRE_1 = 1;
    @(posedge clk); #1;
    chk("read_a_valid", 32'(Data_valid), 1);
    chk("read_a_data", 32'(Data), 32'(enc(8'd5)));
    #1 Reset = 0;
    #1;
    chk("rst_mid_valid", 32'(Data_valid), 0);
    chk("rst_mid_data", 32'(Data), 0);
    chk("rst_mid_busy", 32'(Busy), 0);
    @(negedge clk); Reset = 1; NRE_1 = 0;
    @(negedge clk);
    read_row(0, 8'd0, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
